// File: rtl/lsu_ctrl.sv
// lsu_ctrl: one-outstanding-transaction sequencer for the LSU's AXI4 AW/W/B and AR/R channels.
// Define LSU_CTRL_TIMEOUT_EN to add a TIMEOUT_W-bit watchdog that faults a stalled transaction.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       valid_pre_i,
  output logic       ready_pre_o,
  input  logic       mem_re_i,
  input  logic       mem_we_i,
  output logic       valid_post_o,
  input  logic       ready_post_i,
  output logic       rdata_we_o,
  output logic       awvalid_o,
  input  logic       awready_i,
  output logic       wvalid_o,
  input  logic       wready_i,
  input  logic       bvalid_i,
  output logic       bready_o,
  input  logic [1:0] bresp_i,
  output logic       arvalid_o,
  input  logic       arready_i,
  input  logic       rvalid_i,
  output logic       rready_o,
  input  logic [1:0] rresp_i,
  input  logic       rlast_i,
  output logic       access_fault_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WADDR = 3'd3,
    WRESP = 3'd4,
    DONE  = 3'd5
  } state_e;

  state_e state_q, state_d;
  logic   arvalid_q, awvalid_q, wvalid_q;
  logic   aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic   fault_q, fault_d;
  logic   aw_fire, w_fire;
  logic   timeout;

  assign aw_fire = awvalid_q & awready_i;
  assign w_fire  = wvalid_q & wready_i;

`ifdef LSU_CTRL_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic                 busy;

  assign busy    = (state_q == RADDR) || (state_q == RDATA) ||
                   (state_q == WADDR) || (state_q == WRESP);
  // Fire on the cycle the counter would step to all-ones.
  assign timeout = busy && (timer_q == {{(TIMEOUT_W-1){1'b1}}, 1'b0});

  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (busy) begin
      timer_d = timer_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  logic unused_cfg;
  assign timeout    = 1'b0;
  assign unused_cfg = rlast_i ^ (TIMEOUT_W != 0);
`endif

  always_comb begin
    state_d   = state_q;
    fault_d   = fault_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      IDLE: begin
        if (valid_pre_i) begin
          fault_d = 1'b0;
          if (mem_re_i) begin
            state_d = RADDR;
          end else if (mem_we_i) begin
            state_d = WADDR;
          end else begin
            state_d = DONE;
          end
        end
      end
      RADDR: begin
        if (arready_i) begin
          state_d = RDATA;
        end else if (timeout) begin
          fault_d = 1'b1;
          state_d = DONE;
        end
      end
      RDATA: begin
        if (rvalid_i) begin
          fault_d = |rresp_i;
          state_d = DONE;
        end else if (timeout) begin
          fault_d = 1'b1;
          state_d = DONE;
        end
      end
      WADDR: begin
        // AW and W may complete in either order; each is remembered until the result retires.
        aw_done_d = aw_done_q | aw_fire;
        w_done_d  = w_done_q | w_fire;
        if (aw_done_d && w_done_d) begin
          state_d = WRESP;
        end else if (timeout) begin
          fault_d = 1'b1;
          state_d = DONE;
        end
      end
      WRESP: begin
        if (bvalid_i) begin
          fault_d = |bresp_i;
          state_d = DONE;
        end else if (timeout) begin
          fault_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (ready_post_i) begin
          fault_d   = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      fault_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      fault_q   <= fault_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      arvalid_q <= (state_d == RADDR);
      awvalid_q <= (state_d == WADDR) && !aw_done_d;
      wvalid_q  <= (state_d == WADDR) && !w_done_d;
    end
  end

  assign ready_pre_o    = (state_q == IDLE);
  assign rready_o       = (state_q == RDATA);
  assign bready_o       = (state_q == WRESP);
  assign valid_post_o   = (state_q == DONE);
  assign rdata_we_o     = rready_o & rvalid_i;
  assign access_fault_o = valid_post_o & fault_q;
  assign arvalid_o      = arvalid_q;
  assign awvalid_o      = awvalid_q;
  assign wvalid_o       = wvalid_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed vectors for lsu_ctrl, checked every cycle against a handshake-level model.
// Define LSU_CTRL_TIMEOUT_EN to also exercise the watchdog with TIMEOUT_W=4.
`timescale 1ns/1ps
module tb_lsu_ctrl;

`ifdef LSU_CTRL_TIMEOUT_EN
  localparam int unsigned TW = 4;
`else
  localparam int unsigned TW = 8;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       valid_pre_i, mem_re_i, mem_we_i, ready_post_i;
  logic       awready_i, wready_i, bvalid_i, arready_i, rvalid_i, rlast_i;
  logic [1:0] bresp_i, rresp_i;
  logic       ready_pre_o, valid_post_o, rdata_we_o, awvalid_o, wvalid_o;
  logic       bready_o, arvalid_o, rready_o, access_fault_o;

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  lsu_ctrl #(.TIMEOUT_W(TW)) dut (
    .clock(clock), .reset(reset),
    .valid_pre_i(valid_pre_i), .ready_pre_o(ready_pre_o),
    .mem_re_i(mem_re_i), .mem_we_i(mem_we_i),
    .valid_post_o(valid_post_o), .ready_post_i(ready_post_i),
    .rdata_we_o(rdata_we_o),
    .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i),
    .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rvalid_i(rvalid_i), .rready_o(rready_o), .rresp_i(rresp_i),
    .rlast_i(rlast_i), .access_fault_o(access_fault_o)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  // Model: which handshakes are still owed, and whether a result is waiting for WBU.
  logic m_ar = 0, m_r = 0, m_aw = 0, m_w = 0, m_b = 0, m_post = 0, m_fault = 0;
  int   m_wait = 0;
  logic n_ar, n_r, n_aw, n_w, n_b, n_post, n_fault, m_idle, progress;
  int   n_wait;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_ar = 0; m_r = 0; m_aw = 0; m_w = 0; m_b = 0; m_post = 0; m_fault = 0; m_wait = 0;
    end else begin
      m_idle = !(m_ar | m_r | m_aw | m_w | m_b | m_post);
      n_ar = m_ar; n_r = m_r; n_aw = m_aw; n_w = m_w; n_b = m_b;
      n_post = m_post; n_fault = m_fault; n_wait = m_wait; progress = 0;
      if (m_idle && valid_pre_i) begin
        n_fault = 0;
        if (mem_re_i) n_ar = 1;
        else if (mem_we_i) begin n_aw = 1; n_w = 1; end
        else n_post = 1;
      end
      if (m_ar && arready_i) begin n_ar = 0; n_r = 1; progress = 1; end
      if (m_r && rvalid_i) begin n_r = 0; n_post = 1; n_fault = (rresp_i != 0); progress = 1; end
      if (m_aw || m_w) begin
        if (awready_i) n_aw = 0;
        if (wready_i) n_w = 0;
        if (!n_aw && !n_w) begin n_b = 1; progress = 1; end
      end
      if (m_b && bvalid_i) begin n_b = 0; n_post = 1; n_fault = (bresp_i != 0); progress = 1; end
      if (m_post && ready_post_i) begin n_post = 0; n_fault = 0; end
`ifdef LSU_CTRL_TIMEOUT_EN
      if (m_ar | m_r | m_aw | m_w | m_b) begin
        if (progress) n_wait = 0;
        else if (m_wait + 1 == (1 << TW) - 1) begin
          n_ar = 0; n_r = 0; n_aw = 0; n_w = 0; n_b = 0;
          n_post = 1; n_fault = 1; n_wait = 0;
        end else n_wait = m_wait + 1;
      end
`endif
      m_ar = n_ar; m_r = n_r; m_aw = n_aw; m_w = n_w; m_b = n_b;
      m_post = n_post; m_fault = n_fault; m_wait = n_wait;
    end
  end

  always @(negedge clock) begin
    checkOutput("m_ready_pre", ready_pre_o, !(m_ar | m_r | m_aw | m_w | m_b | m_post));
    checkOutput("m_arvalid", arvalid_o, m_ar);
    checkOutput("m_rready", rready_o, m_r);
    checkOutput("m_rdata_we", rdata_we_o, m_r & rvalid_i);
    checkOutput("m_awvalid", awvalid_o, m_aw);
    checkOutput("m_wvalid", wvalid_o, m_w);
    checkOutput("m_bready", bready_o, m_b);
    checkOutput("m_valid_post", valid_post_o, m_post);
    checkOutput("m_fault", access_fault_o, m_post & m_fault);
  end

  task automatic applyStimulus(input logic vp, input logic re, input logic we);
    valid_pre_i = vp; mem_re_i = re; mem_we_i = we;
  endtask

  task automatic clearInputs();
    applyStimulus(0, 0, 0);
    ready_post_i = 0; awready_i = 0; wready_i = 0; bvalid_i = 0;
    arready_i = 0; rvalid_i = 0; rlast_i = 0; bresp_i = 0; rresp_i = 0;
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  int cnt;

  initial begin
    clearInputs();
    reset = 0;
    step();
    #1;
    checkOutput("rst_ready_pre", ready_pre_o, 1);
    checkOutput("rst_arvalid", arvalid_o, 0);
    checkOutput("rst_valid_post", valid_post_o, 0);
    step();
    reset = 1;
    step();

    // Zero-wait load
    applyStimulus(1, 1, 0);
    step();
    applyStimulus(0, 0, 0); arready_i = 1; #1;
    checkOutput("ld_arvalid_t1", arvalid_o, 1);
    step();
    arready_i = 0; rvalid_i = 1; #1;
    checkOutput("ld_rdata_we_t2", rdata_we_o, 1);
    step();
    rvalid_i = 0; ready_post_i = 1; #1;
    checkOutput("ld_valid_post_t3", valid_post_o, 1);
    checkOutput("ld_fault_t3", access_fault_o, 0);
    step();
    ready_post_i = 0;

    // Store: AW at T+1, W delayed to T+3
    applyStimulus(1, 0, 1);
    step();
    applyStimulus(0, 0, 0); awready_i = 1; #1;
    checkOutput("st_awvalid_t1", awvalid_o, 1);
    checkOutput("st_wvalid_t1", wvalid_o, 1);
    step();
    awready_i = 0; #1;
    checkOutput("st_awvalid_t2", awvalid_o, 0);
    checkOutput("st_wvalid_t2", wvalid_o, 1);
    step();
    wready_i = 1; #1;
    checkOutput("st_wvalid_t3", wvalid_o, 1);
    step();
    wready_i = 0; bvalid_i = 1; #1;
    checkOutput("st_bready_t4", bready_o, 1);
    checkOutput("st_wvalid_t4", wvalid_o, 0);
    step();
    bvalid_i = 0; ready_post_i = 1; #1;
    checkOutput("st_valid_post", valid_post_o, 1);
    step();
    ready_post_i = 0;

    // Load with SLVERR held in DONE for 5 cycles
    applyStimulus(1, 1, 0);
    step();
    applyStimulus(0, 0, 0); arready_i = 1;
    step();
    arready_i = 0; rvalid_i = 1; rresp_i = 2'b10;
    step();
    rvalid_i = 0; rresp_i = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("err_valid_post_hold", valid_post_o, 1);
      checkOutput("err_fault_hold", access_fault_o, 1);
      step();
    end
    ready_post_i = 1;
    step();
    ready_post_i = 0; #1;
    checkOutput("err_back_idle", ready_pre_o, 1);
    checkOutput("err_fault_cleared", access_fault_o, 0);

    // Non-memory pass-through, then back-to-back load
    applyStimulus(1, 0, 0);
    step();
    #1;
    checkOutput("nm_valid_post_t1", valid_post_o, 1);
    checkOutput("nm_no_arvalid", arvalid_o, 0);
    checkOutput("nm_no_awvalid", awvalid_o, 0);
    ready_post_i = 1;
    step();
    ready_post_i = 0; applyStimulus(1, 1, 1); #1;
    checkOutput("b2b_ready_pre", ready_pre_o, 1);
    step();
    applyStimulus(0, 0, 0); arready_i = 1; #1;
    checkOutput("both_load_wins_ar", arvalid_o, 1);
    checkOutput("both_load_wins_aw", awvalid_o, 0);
    step();
    arready_i = 0; rvalid_i = 1;
    step();
    rvalid_i = 0; ready_post_i = 1;
    step();
    ready_post_i = 0;

    // Reset in the middle of a store
    applyStimulus(1, 0, 1);
    step();
    applyStimulus(0, 0, 0); #1;
    checkOutput("rst_pre_awvalid", awvalid_o, 1);
    reset = 0; #1;
    checkOutput("rst_mid_awvalid", awvalid_o, 0);
    checkOutput("rst_mid_wvalid", wvalid_o, 0);
    checkOutput("rst_mid_ready_pre", ready_pre_o, 1);
    step();
    reset = 1;
    applyStimulus(1, 0, 0);
    step();
    applyStimulus(0, 0, 0); ready_post_i = 1; #1;
    checkOutput("post_rst_valid_post", valid_post_o, 1);
    checkOutput("post_rst_awvalid", awvalid_o, 0);
    step();
    ready_post_i = 0;

`ifdef LSU_CTRL_TIMEOUT_EN
    // Watchdog: AR never accepted
    applyStimulus(1, 1, 0);
    step();
    applyStimulus(0, 0, 0);
    cnt = 0;
    #1;
    while (!valid_post_o && cnt < 40) begin
      cnt++;
      step();
      #1;
    end
    checkOutput("to_raddr_cycles", cnt, 15);
    checkOutput("to_fault", access_fault_o, 1);
    checkOutput("to_arvalid", arvalid_o, 0);
    ready_post_i = 1;
    step();
    ready_post_i = 0;
`endif

    step();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Sequencing controller for the LSU datapath. It accepts one instruction at a time from the upstream stage and drives the AXI4 valid/ready handshakes for the LSU's AW/W/B and AR/R channels; address, data, strobe and size come from the LSU datapath. It pulses the LSU's read-data capture enable and hands the finished instruction to WBU with a valid/ready handshake. Exactly one transaction is outstanding at any time.

## Interface
- `TIMEOUT_W`, 8: width of the watchdog counter. Used only when `LSU_CTRL_TIMEOUT_EN` is defined.
- `clock` in 1: the single clock.
- `reset` in 1: asynchronous, active-low reset.
- `valid_pre_i` in 1: upstream has an instruction.
- `ready_pre_o` out 1: controller can accept an instruction.
- `mem_re_i` in 1: the instruction is a load. Sampled at accept.
- `mem_we_i` in 1: the instruction is a store. Sampled at accept.
- `valid_post_o` out 1: result is ready for WBU.
- `ready_post_i` in 1: WBU accepts the result.
- `rdata_we_o` out 1: capture enable to the LSU (its `rdata_we_i`).
- `awvalid_o` out 1, `awready_i` in 1: AXI4 AW handshake.
- `wvalid_o` out 1, `wready_i` in 1: AXI4 W handshake.
- `bvalid_i` in 1, `bready_o` out 1: AXI4 B handshake.
- `bresp_i` in 2: AXI4 write response.
- `arvalid_o` out 1, `arready_i` in 1: AXI4 AR handshake.
- `rvalid_i` in 1, `rready_o` out 1: AXI4 R handshake.
- `rresp_i` in 2: AXI4 read response.
- `rlast_i` in 1: ignored; all transfers are single beat.
- `access_fault_o` out 1: fault flag, qualified by `valid_post_o`.

## Operation
- States: IDLE, RADDR, RDATA, WADDR, WRESP, DONE.
- IDLE
  - `ready_pre_o`=1 only in IDLE.
  - On `valid_pre_i`: if `mem_re_i`=1, go to RADDR.
  - Else if `mem_we_i`=1, go to WADDR.
  - Else go to DONE (non-memory pass-through).
  - If `mem_re_i` and `mem_we_i` are both 1, load wins.
- RADDR
  - `arvalid_o`=1, held until `arready_i`; the address must stay stable.
  - On `arready_i`, go to RDATA.
- RDATA
  - `rready_o`=1.
  - On `rvalid_i`: `rdata_we_o`=1 in that same cycle (combinational), latch fault = (`rresp_i` != 0), go to DONE.
- WADDR
  - `awvalid_o` and `wvalid_o` assert together.
  - Sticky flags `aw_done`/`w_done` track each handshake independently. Each valid drops the cycle after its own handshake.
  - Go to WRESP once both handshakes have completed, whether in the same cycle or in different cycles.
- WRESP
  - `bready_o`=1.
  - On `bvalid_i`: latch fault = (`bresp_i` != 0), go to DONE.
- DONE
  - `valid_post_o`=1 and `access_fault_o` = latched fault.
  - On `ready_post_i`: clear fault, clear `aw_done`/`w_done`, go to IDLE.
  - Back-to-back: the next accept can happen the cycle after the DONE handshake.
- All AXI valids are registered outputs. `rready_o`, `bready_o`, `ready_pre_o`, `valid_post_o` and `rdata_we_o` are decoded from state.

## Timing
- Reset values (`reset`=0, asynchronous): state IDLE; every valid/ready output 0 except `ready_pre_o`=1; `rdata_we_o`=0; `access_fault_o`=0; flags and counter 0.
- Reset asserted mid-transaction aborts immediately. No further handshakes follow, and the first accept after reset release is clean.
- Latency, accept at cycle T, zero-wait slave:
  - Load: `arvalid_o` at T+1, RDATA at T+2, `rvalid_i` at T+2 → `valid_post_o` at T+3.
  - Store: AW/W at T+1, WRESP at T+2, `bvalid_i` at T+2 → `valid_post_o` at T+3.
  - Non-memory: `valid_post_o` at T+1.
- Each slave wait cycle adds exactly one cycle.
- `valid_post_o` holds while `ready_post_i`=0; state and outputs stay frozen.

## Configuration
- `LSU_CTRL_TIMEOUT_EN` defined:
  - A `TIMEOUT_W`-bit counter clears on every state change and increments each cycle in RADDR, RDATA, WADDR or WRESP.
  - When it reaches all-ones: drop all AXI valids/readies, set fault=1, go to DONE. `rdata_we_o` stays 0.
- Undefined: no counter; the controller waits indefinitely for the slave.

## Test plan
- Load, zero-wait slave, `rresp_i`=0: accept at T → `arvalid_o` at T+1, `rdata_we_o` pulse at T+2, `valid_post_o`=1 with `access_fault_o`=0 at T+3.
- Store with `awready_i` at T+1 and `wready_i` delayed to T+3: `awvalid_o` drops at T+2, `wvalid_o` held until T+3, WRESP entered at T+4.
- Load with `rresp_i`=2'b10: `access_fault_o`=1 with `valid_post_o`; with `ready_post_i` held low for 5 cycles, outputs stay stable, then return to IDLE.
- Non-memory instruction: `valid_post_o` at T+1 with no AXI valid ever asserted; back-to-back accept the cycle after the handshake.
- `reset` asserted while in WADDR with `awvalid_o`=1: `awvalid_o`/`wvalid_o` fall immediately and `ready_pre_o`=1.
- With `LSU_CTRL_TIMEOUT_EN` and `TIMEOUT_W`=4, `arready_i` never asserted: DONE with `access_fault_o`=1 after 15 cycles in RADDR.
